// File: rtl/addr_resp_collect_if.sv
// Signal bundle between the initiator/decoder side, the targets and addr_resp_collect.
// The collector uses the slave modport; the environment driving it uses master.
interface addr_resp_collect_if #(
  parameter int NoIndices = 4,
  parameter int DataWidth = 32,
  parameter int IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
);
  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [IdxWidth-1:0]            req_idx_i;
  logic                           req_err_i;
  logic [NoIndices-1:0]           tgt_rsp_valid_i;
  logic [NoIndices*DataWidth-1:0] tgt_rsp_data_i;
  logic [NoIndices-1:0]           tgt_rsp_ready_o;
  logic                           rsp_valid_o;
  logic [DataWidth-1:0]           rsp_data_o;
  logic                           rsp_err_o;
  logic                           rsp_ready_i;
  logic                           unexpected_rsp_o;

  modport slave (
    input  req_valid_i, req_idx_i, req_err_i,
    input  tgt_rsp_valid_i, tgt_rsp_data_i, rsp_ready_i,
    output req_ready_o, tgt_rsp_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, unexpected_rsp_o
  );

  modport master (
    output req_valid_i, req_idx_i, req_err_i,
    output tgt_rsp_valid_i, tgt_rsp_data_i, rsp_ready_i,
    input  req_ready_o, tgt_rsp_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, unexpected_rsp_o
  );
endinterface

// File: rtl/addr_resp_collect.sv
// In-order response collector: tracks {err, idx} of each decoded request and returns
// target responses (or local decode errors) to the initiator through a registered stage.
module addr_resp_collect #(
  parameter int NoIndices = 4,
  parameter int MaxTrans  = 4,
  parameter int DataWidth = 32,
  parameter int IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
  input logic                clk_i,
  input logic                rst_i,
  addr_resp_collect_if.slave bus
);
  localparam int CntWidth = $clog2(MaxTrans + 1);
  localparam int PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxTrans);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxTrans - 1);

  logic [IdxWidth-1:0] idx_mem [MaxTrans];
  logic                err_mem [MaxTrans];

  logic [CntWidth-1:0]  count_reg, count_next;
  logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [DataWidth-1:0] rsp_data_reg, rsp_data_next;
  logic                 rsp_err_reg, rsp_err_next;
  logic                 unexpected_reg, unexpected_next;

  logic                 req_ready;
  logic                 push;
  logic                 pop;
  logic                 out_free;
  logic                 head_valid;
  logic                 head_err;
  logic                 head_tgt_valid;
  logic [IdxWidth-1:0]  head_idx;
  logic [IdxWidth-1:0]  push_idx;
  logic [NoIndices-1:0] head_hit;
  logic [DataWidth-1:0] head_data;

  // Full blocks the push even when a pop happens in the same cycle.
  assign req_ready = !rst_i && (count_reg != CntFull);
  assign push      = bus.req_valid_i && req_ready;

  // Illegal indices are folded to target 0 so nothing is ever addressed out of range.
  assign push_idx = (int'(bus.req_idx_i) < NoIndices) ? bus.req_idx_i : '0;

  assign head_valid = (count_reg != '0);
  assign head_idx   = idx_mem[rd_ptr_reg];
  assign head_err   = err_mem[rd_ptr_reg];
  assign out_free   = !rsp_valid_reg || bus.rsp_ready_i;

  genvar gi;
  generate
    for (gi = 0; gi < NoIndices; gi++) begin : g_tgt
      assign head_hit[gi] = (head_idx == IdxWidth'(gi));
      assign bus.tgt_rsp_ready_o[gi] = head_valid && !head_err && head_hit[gi] && out_free;
    end
  endgenerate

  always_comb begin
    head_data = '0;
    for (int k = 0; k < NoIndices; k++) begin
      if (head_hit[k]) head_data = bus.tgt_rsp_data_i[k*DataWidth +: DataWidth];
    end
  end

  assign head_tgt_valid = |(bus.tgt_rsp_valid_i & head_hit);
  assign pop = head_valid && out_free && (head_err || head_tgt_valid);

  always_comb begin
    count_next      = count_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_data_next   = rsp_data_reg;
    rsp_err_next    = rsp_err_reg;
    unexpected_next = unexpected_reg;

    if (push) wr_ptr_next = (wr_ptr_reg == PtrLast) ? '0 : wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = (rd_ptr_reg == PtrLast) ? '0 : rd_ptr_reg + 1'b1;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (pop) begin
      rsp_valid_next = 1'b1;
      rsp_data_next  = head_err ? '0 : head_data;
      rsp_err_next   = head_err;
    end else if (rsp_valid_reg && bus.rsp_ready_i) begin
      rsp_valid_next = 1'b0;
    end

    if (!head_valid && |bus.tgt_rsp_valid_i) unexpected_next = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_err_reg    <= 1'b0;
      unexpected_reg <= 1'b0;
    end else begin
      count_reg      <= count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_err_reg    <= rsp_err_next;
      unexpected_reg <= unexpected_next;
    end
  end

  // Tracking storage carries no reset; entries are only read while count says they are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem[wr_ptr_reg] <= push_idx;
      err_mem[wr_ptr_reg] <= bus.req_err_i;
    end
  end

  assign bus.req_ready_o      = req_ready;
  assign bus.rsp_valid_o      = rsp_valid_reg;
  assign bus.rsp_data_o       = rsp_data_reg;
  assign bus.rsp_err_o        = rsp_err_reg;
  assign bus.unexpected_rsp_o = unexpected_reg;
endmodule
